sh_ram_writer: RTL and testbench

SH_RAM_WRITER -- requirements
Module: sh_ram_writer

---
 rtl/sh_ram_writer_if.sv | 22 ++
 rtl/sh_ram_writer.sv | 135 +++++++++++++
 tb/tb_sh_ram_writer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sh_ram_writer_if.sv
// Request/result handshake plus the sh_ram write port of sh_ram_writer.
// The writer takes the master modport; the requester and RAM side take the slave modport.
interface sh_ram_writer_if;
    logic        start;
    logic [16:0] val_a;
    logic [16:0] val_b;
    logic        busy;
    logic        done;
    logic        sh_ram_we;
    logic [3:0]  sh_ram_waddr;
    logic [3:0]  sh_ram_wdata;

    modport master (
        input  start, val_a, val_b,
        output busy, done, sh_ram_we, sh_ram_waddr, sh_ram_wdata
    );

    modport slave (
        output start, val_a, val_b,
        input  busy, done, sh_ram_we, sh_ram_waddr, sh_ram_wdata
    );
endinterface

// File: rtl/sh_ram_writer.sv
// Converts two saturated 17-bit values to five BCD digits each by serial double-dabble
// and writes them to sh_ram addresses 0-9, with optional leading-zero blanking.
module sh_ram_writer #(
    parameter bit         LZ_BLANK   = 1'b0,
    parameter logic [3:0] BLANK_CODE = 4'd10
) (
    input  logic           clk,
    input  logic           rst,
    sh_ram_writer_if.master bus
);
    typedef enum logic [2:0] {IDLE, CONV_A, WR_A, CONV_B, WR_B, DONE} state_t;

    localparam logic [16:0] MAX_VAL = 17'd99999;

    state_t      state, state_next;
    logic [16:0] shift_q;
    logic [16:0] val_b_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;
    logic [19:0] bcd_next;
    logic [4:0]  cnt_q;
    logic        we_q;
    logic [3:0]  waddr_q;
    logic [3:0]  wdata_q;
    logic        conv_last;
    logic        wr_last;

    function automatic logic [16:0] saturate(input logic [16:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // idx 0 is the ten-thousands digit; a digit is blanked only when it and
    // every more significant digit are zero, and the units digit never is.
    function automatic logic [3:0] digit_code(input logic [19:0] bcd, input int idx);
        logic lead_zero;
        lead_zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i <= idx && bcd[19-4*i -: 4] != 4'd0) lead_zero = 1'b0;
        end
        if (LZ_BLANK && idx != 4 && lead_zero) return BLANK_CODE;
        return bcd[19-4*idx -: 4];
    endfunction

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[18:0], shift_q[16]};
    end

    assign conv_last = (cnt_q == 5'd16);
    assign wr_last   = (cnt_q == 5'd4);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = CONV_A;
            CONV_A:  if (conv_last) state_next = WR_A;
            WR_A:    if (wr_last)   state_next = CONV_B;
            CONV_B:  if (conv_last) state_next = WR_B;
            WR_B:    if (wr_last)   state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset explicitly; this is flop state, not a memory array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            val_b_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_q <= saturate(bus.val_a);
                        val_b_q <= saturate(bus.val_b);
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CONV_A, CONV_B: begin
                    shift_q <= shift_q << 1;
                    bcd_q   <= bcd_next;
                    if (conv_last) begin
                        // The first digit leaves on the edge that finishes the conversion.
                        cnt_q   <= '0;
                        we_q    <= 1'b1;
                        waddr_q <= (state == CONV_B) ? 4'd5 : 4'd0;
                        wdata_q <= digit_code(bcd_next, 0);
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                WR_A, WR_B: begin
                    if (wr_last) begin
                        cnt_q <= '0;
                        if (state == WR_A) begin
                            shift_q <= val_b_q;
                            bcd_q   <= '0;
                        end
                    end else begin
                        cnt_q   <= cnt_q + 5'd1;
                        we_q    <= 1'b1;
                        waddr_q <= waddr_q + 4'd1;
                        wdata_q <= digit_code(bcd_q, int'(cnt_q) + 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.sh_ram_we    = we_q;
    assign bus.sh_ram_waddr = waddr_q;
    assign bus.sh_ram_wdata = wdata_q;
endmodule

// File: tb/tb_sh_ram_writer.sv
// Directed bench: two writers (blanking off/on) share stimulus; every output is
// compared every cycle of each sequence against hand-computed digit strings.
module tb_sh_ram_writer;
    logic        clk;
    logic        rst;
    logic        start;
    logic [16:0] val_a;
    logic [16:0] val_b;

    int n_checks = 0;
    int n_pass   = 0;

    sh_ram_writer_if if0 ();
    sh_ram_writer_if if1 ();

    assign if0.start = start;
    assign if0.val_a = val_a;
    assign if0.val_b = val_b;
    assign if1.start = start;
    assign if1.val_a = val_a;
    assign if1.val_b = val_b;

    sh_ram_writer #(.LZ_BLANK(1'b0), .BLANK_CODE(4'd10)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    sh_ram_writer #(.LZ_BLANK(1'b1), .BLANK_CODE(4'd10)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [1:0] obs_busy, obs_done, obs_we;
    logic [3:0] obs_addr [2];
    logic [3:0] obs_data [2];

    assign obs_busy    = {if1.busy, if0.busy};
    assign obs_done    = {if1.done, if0.done};
    assign obs_we      = {if1.sh_ram_we, if0.sh_ram_we};
    assign obs_addr[0] = if0.sh_ram_waddr;
    assign obs_addr[1] = if1.sh_ram_waddr;
    assign obs_data[0] = if0.sh_ram_wdata;
    assign obs_data[1] = if1.sh_ram_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_quiet(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s dut%0d busy", tag, k), 32'(obs_busy[k]), 32'd0);
            check($sformatf("%s dut%0d done", tag, k), 32'(obs_done[k]), 32'd0);
            check($sformatf("%s dut%0d we", tag, k), 32'(obs_we[k]), 32'd0);
            check($sformatf("%s dut%0d addr", tag, k), 32'(obs_addr[k]), 32'd0);
            check($sformatf("%s dut%0d data", tag, k), 32'(obs_data[k]), 32'd0);
        end
    endtask

    // One IDLE cycle with start low.
    task automatic idle_cycle(input string tag);
        @(negedge clk);
        start = 1'b0;
        check_quiet(tag);
    endtask

    // Called at a negedge with both writers idle: that cycle is cycle 0.
    // e0/e1 hold the ten expected digit codes (address 0 in the top nibble).
    task automatic run_seq(input string name, input logic [16:0] a, input logic [16:0] b,
                           input logic [39:0] e0, input logic [39:0] e1,
                           input bit extra, input bit wiggle, input int rst_at);
        logic [39:0] e;
        int          exp_we, exp_addr, exp_data;
        start = 1'b1;
        val_a = a;
        val_b = b;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (wiggle) begin
                val_a = 17'($urandom);
                val_b = 17'($urandom);
            end
            for (int k = 0; k < 2; k++) begin
                e        = (k == 0) ? e0 : e1;
                exp_we   = 0;
                exp_addr = 0;
                exp_data = 0;
                if (c >= 18 && c <= 22) begin
                    exp_we   = 1;
                    exp_addr = c - 18;
                    exp_data = int'(e[39-4*(c-18) -: 4]);
                end else if (c >= 40 && c <= 44) begin
                    exp_we   = 1;
                    exp_addr = c - 35;
                    exp_data = int'(e[39-4*(c-35) -: 4]);
                end
                check($sformatf("%s c%0d dut%0d busy", name, c, k), 32'(obs_busy[k]), 32'd1);
                check($sformatf("%s c%0d dut%0d done", name, c, k), 32'(obs_done[k]), (c == 45) ? 32'd1 : 32'd0);
                check($sformatf("%s c%0d dut%0d we", name, c, k), 32'(obs_we[k]), 32'(exp_we));
                check($sformatf("%s c%0d dut%0d addr", name, c, k), 32'(obs_addr[k]), 32'(exp_addr));
                check($sformatf("%s c%0d dut%0d data", name, c, k), 32'(obs_data[k]), 32'(exp_data));
            end
            if (extra && (c == 10 || c == 30 || c == 45)) start = 1'b1;
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check_quiet($sformatf("%s async rst", name));
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    check_quiet($sformatf("%s in rst %0d", name, r));
                end
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        val_a = '0;
        val_b = '0;
        #2;
        check_quiet("reset before clock");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_quiet("after reset");

        // Basic vector, then a restart in cycle 46.
        run_seq("basic", 17'd12345, 17'd678, 40'h12345_00678, 40'h12345_AA678, 1'b0, 1'b0, 0);
        idle_cycle("basic c46");
        // Over-range and full-nines, with ignored start pulses in cycles 10, 30, 45.
        run_seq("sat", 17'd131071, 17'd99999, 40'h99999_99999, 40'h99999_99999, 1'b1, 1'b0, 0);
        idle_cycle("sat c46");
        idle_cycle("sat c47");
        run_seq("zero", 17'd0, 17'd7, 40'h00000_00007, 40'hAAAA0_AAAA7, 1'b0, 1'b0, 0);
        idle_cycle("zero c46");
        run_seq("edge", 17'd10, 17'd100000, 40'h00010_99999, 40'hAAA10_99999, 1'b0, 1'b0, 0);
        idle_cycle("edge c46");
        // Inputs toggle every cycle after capture.
        run_seq("wiggle", 17'd54321, 17'd100, 40'h54321_00100, 40'h54321_AA100, 1'b0, 1'b1, 0);
        idle_cycle("wiggle c46");
        // Reset in the middle of cycle 20, then a clean run.
        run_seq("abort", 17'd24680, 17'd13579, 40'h24680_13579, 40'h24680_13579, 1'b0, 1'b0, 20);
        idle_cycle("abort idle");
        run_seq("after abort", 17'd40000, 17'd5, 40'h40000_00005, 40'h40000_AAAA5, 1'b0, 1'b0, 0);
        idle_cycle("after abort c46");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
